// File: rtl/stream_mux_rr.sv
// Selects one of NCH valid/ready streams onto one registered output stream.
// The channel is chosen either by an explicit index or by round-robin arbitration.
module stream_mux_rr #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 8,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  last;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_any;
  logic [NCH-1:0]   grant;
  logic [WIDTH-1:0] sel_data;
  logic             load_en;
  int               idx;

  assign load_en  = !out_valid || out_ready;
  assign in_ready = load_en ? grant : '0;

  // Grant search: explicit index in mode 0, first valid after last in mode 1.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (!mode) begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= int'(NCH); k++) begin
        idx = (int'(last) + k) % int'(NCH);
        if (!gnt_any && in_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    grant    = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (gnt_any && gnt_idx == SELW'(i)) begin
        grant[i] = 1'b1;
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register refills in the same cycle the held word drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      last      <= SELW'(NCH - 1);
    end else if (load_en) begin
      if (gnt_any) begin
        out_data  <= sel_data;
        out_ch    <= gnt_idx;
        out_valid <= 1'b1;
        if (mode) begin
          last <= gnt_idx;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios plus random traffic, with a
// reference model feeding a scoreboard that a separate monitor drains.
module tb_stream_mux_rr;
  localparam int unsigned NCH   = 8;
  localparam int unsigned WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          m_valid;
  int          m_last;
  logic [63:0] cdata;
  int          p4_seq[6];

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic [7:0] v, input logic m, input logic [2:0] s,
                       input logic r, input logic [63:0] d);
    in_valid  = v;
    mode      = m;
    sel       = s;
    out_ready = r;
    in_data   = d;
  endtask

  // Reference: grant rules applied to the currently driven inputs and model state.
  task automatic model_step();
    int         g;
    bit         ld;
    logic [7:0] exp_rdy;
    exp_t       e;
    ld = !m_valid || out_ready;
    g  = -1;
    if (!mode) begin
      if (int'(sel) < int'(NCH) && in_valid[sel]) g = int'(sel);
    end else begin
      for (int d = 1; d <= int'(NCH); d++) begin
        int c;
        c = (m_last + d) % int'(NCH);
        if (g < 0 && in_valid[c]) g = c;
      end
    end
    exp_rdy = (ld && g >= 0) ? 8'(1 << g) : 8'h00;
    chk("in_ready", {24'b0, in_ready}, {24'b0, exp_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (exp_rdy != 8'h00) begin
      e.ch   = g;
      e.data = in_data[g*8 +: 8];
      sb.push_back(e);
      m_valid = 1'b1;
      if (mode) m_last = g;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic [7:0] v, input logic m, input logic [2:0] s,
                       input logic r, input logic [63:0] d);
    drive(v, m, s, r, d);
    #1;
    model_step();
    tick();
  endtask

  task automatic do_reset(input logic [7:0] v);
    in_valid = v;
    rst_n    = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {24'b0, out_data}, 32'd0);
    chk("rst_out_ch", {29'b0, out_ch}, 32'd0);
    sb.delete();
    m_valid = 1'b0;
    m_last  = int'(NCH) - 1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: every word the consumer accepts must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_out_ch", {29'b0, out_ch}, 32'(e.ch));
          chk("sb_out_data", {24'b0, out_data}, {24'b0, e.data});
        end
      end
    end
  end

  initial begin
    cdata  = 64'hddccbbaa78563412;
    p4_seq = '{2, 5, 7, 2, 5, 7};
    rst_n  = 1'b1;
    drive(8'hff, 1'b0, 3'd2, 1'b1, cdata);
    #2;

    // Explicit select from reset, then an asynchronous reset mid-stream.
    do_reset(8'hff);
    drive(8'hff, 1'b0, 3'd2, 1'b1, cdata);
    #1;
    chk("p1_in_ready", {24'b0, in_ready}, 32'h04);
    model_step();
    tick();
    chk("p1_out_data", {24'b0, out_data}, 32'h56);
    chk("p1_out_ch", {29'b0, out_ch}, 32'd2);
    chk("p1_out_valid", {31'b0, out_valid}, 32'd1);
    cycle(8'hff, 1'b0, 3'd2, 1'b1, cdata);
    do_reset(8'hff);

    // Highest channel, then drain when it drops valid.
    cycle(8'hff, 1'b0, 3'd7, 1'b1, cdata);
    chk("p2_out_data", {24'b0, out_data}, 32'hdd);
    chk("p2_out_ch", {29'b0, out_ch}, 32'd7);
    cycle(8'h7f, 1'b0, 3'd7, 1'b1, cdata);
    chk("p2_drained", {31'b0, out_valid}, 32'd0);
    chk("p2_hold_data", {24'b0, out_data}, 32'hdd);

    // Round-robin fairness with all channels valid.
    do_reset(8'h00);
    for (int k = 0; k < 16; k++) begin
      cycle(8'hff, 1'b1, 3'd0, 1'b1, cdata);
      chk("p3_out_ch", {29'b0, out_ch}, 32'(k % 8));
      chk("p3_out_data", {24'b0, out_data}, {24'b0, cdata[(k % 8)*8 +: 8]});
    end

    // Sparse requesters wrap around.
    do_reset(8'h00);
    for (int k = 0; k < 6; k++) begin
      cycle(8'ha4, 1'b1, 3'd0, 1'b1, cdata);
      chk("p4_out_ch", {29'b0, out_ch}, 32'(p4_seq[k]));
    end

    // Backpressure holds the word, release loads the next with no bubble.
    do_reset(8'h00);
    cycle(8'hff, 1'b0, 3'd3, 1'b1, cdata);
    chk("p5_out_data", {24'b0, out_data}, 32'h78);
    for (int k = 0; k < 5; k++) begin
      cycle(8'hff, 1'b1, 3'd0, 1'b0, cdata);
      chk("p5_stall_data", {24'b0, out_data}, 32'h78);
      chk("p5_stall_ready", {24'b0, in_ready}, 32'h00);
    end
    drive(8'hff, 1'b1, 3'd0, 1'b1, cdata);
    #1;
    chk("p5_release_ready", {24'b0, in_ready}, 32'h01);
    model_step();
    tick();
    chk("p5_next_data", {24'b0, out_data}, 32'h12);
    chk("p5_next_valid", {31'b0, out_valid}, 32'd1);

    // Explicit-mode transfers leave the round-robin pointer untouched.
    do_reset(8'h00);
    cycle(8'h08, 1'b1, 3'd0, 1'b1, cdata);
    chk("p6_rr_ch", {29'b0, out_ch}, 32'd3);
    for (int k = 0; k < 2; k++) begin
      cycle(8'hff, 1'b0, 3'd0, 1'b1, cdata);
      chk("p6_sel_ch", {29'b0, out_ch}, 32'd0);
    end
    cycle(8'hff, 1'b1, 3'd0, 1'b1, cdata);
    chk("p6_resume_ch", {29'b0, out_ch}, 32'd4);

    // Random traffic against the model.
    do_reset(8'h00);
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] v;
      v = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      cycle(v, mode, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            {$urandom, $urandom});
    end
    for (int k = 0; k < 3; k++) cycle(8'h00, mode, 3'd0, 1'b1, cdata);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
